// File: rtl/serial2parallel.sv
// Serial-to-parallel frame receiver: synchronizes an external serial clock/data pair,
// assembles DATA_BITS-wide frames, and ends a frame after IDLE_CYCLES quiet clk cycles.
module serial2parallel #(
    parameter int DATA_BITS      = 64,
    parameter int READ_DIRECTION = 0,
    parameter int IDLE_CYCLES    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_clk,
    input  logic                 s_dat,
    input  logic                 s_clr,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 err,
    output logic                 busy
);

    // bit_cnt must hold DATA_BITS+1 (saturation value); idle_cnt must hold IDLE_CYCLES
    localparam int CNT_W  = $clog2(DATA_BITS + 2);
    localparam int IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DATA_BITS);
    localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(DATA_BITS + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] sr_q, sr_d;
    logic [DATA_BITS-1:0] data_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;
    logic                 valid_d, err_d;

    logic [2:0] clk_sync;
    logic [1:0] dat_sync;
    logic [1:0] clr_sync;
    logic       s_edge;
    logic       bit_in;
    logic       clr_n;

    // Synchronizers; clk_sync[2] is the extra flop for a single-cycle edge pulse.
    // s_clr resets to its inactive (high) level.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= '0;
            dat_sync <= '0;
            clr_sync <= '1;
        end else begin
            clk_sync <= {clk_sync[1:0], s_clk};
            dat_sync <= {dat_sync[0], s_dat};
            clr_sync <= {clr_sync[0], s_clr};
        end
    end

    assign s_edge = clk_sync[1] & ~clk_sync[2];
    assign bit_in = dat_sync[1];
    assign clr_n  = clr_sync[1];

    function automatic logic [DATA_BITS-1:0] shift_in(input logic [DATA_BITS-1:0] sr,
                                                      input logic b);
        if (READ_DIRECTION == 0)
            return {sr[DATA_BITS-2:0], b};
        else
            return {b, sr[DATA_BITS-1:1]};
    endfunction

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        bit_cnt_d  = bit_cnt_q;
        idle_cnt_d = idle_cnt_q;
        data_d     = data;
        valid_d    = 1'b0;
        err_d      = 1'b0;

        if (!clr_n) begin
            state_d    = IDLE;
            sr_d       = '0;
            bit_cnt_d  = '0;
            idle_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s_edge) begin
                        state_d    = RECV;
                        sr_d       = shift_in(sr_q, bit_in);
                        bit_cnt_d  = CNT_W'(1);
                        idle_cnt_d = '0;
                    end
                end
                RECV: begin
                    if (s_edge) begin
                        sr_d       = shift_in(sr_q, bit_in);
                        idle_cnt_d = '0;
                        if (bit_cnt_q != CNT_SAT)
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end else if (idle_cnt_q == IDLE_LAST) begin
                        // idle count reaches IDLE_CYCLES this cycle: frame ends now
                        state_d    = IDLE;
                        idle_cnt_d = '0;
                        if (bit_cnt_q == CNT_FULL) begin
                            data_d  = sr_q;
                            valid_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            idle_cnt_q <= '0;
            data       <= '0;
            valid      <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            data       <= data_d;
            valid      <= valid_d;
            err        <= err_d;
        end
    end

    assign busy = (state_q == RECV);

endmodule

// File: tb/tb_serial2parallel.sv
// Directed bench: MSB-first and LSB-first instances share one serial stream.
module tb_serial2parallel;

    logic        clk = 1'b0;
    logic        rst, s_clk, s_dat, s_clr;
    logic [15:0] data0, data1;
    logic        valid0, err0, busy0, valid1, err1, busy1;

    serial2parallel #(.DATA_BITS(16), .READ_DIRECTION(0), .IDLE_CYCLES(16)) dut0 (
        .clk(clk), .rst(rst), .s_clk(s_clk), .s_dat(s_dat), .s_clr(s_clr),
        .data(data0), .valid(valid0), .err(err0), .busy(busy0));

    serial2parallel #(.DATA_BITS(16), .READ_DIRECTION(1), .IDLE_CYCLES(16)) dut1 (
        .clk(clk), .rst(rst), .s_clk(s_clk), .s_dat(s_dat), .s_clr(s_clr),
        .data(data1), .valid(valid1), .err(err1), .busy(busy1));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int last_rise = 0;
    int vcnt0, ecnt0, vcnt1, ecnt1, vlat0, elat0;
    int total = 0;
    int bad   = 0;

    always @(negedge clk) begin
        if (valid0) begin vcnt0++; vlat0 = cyc - last_rise; end
        if (err0)   begin ecnt0++; elat0 = cyc - last_rise; end
        if (valid1) vcnt1++;
        if (err1)   ecnt1++;
    end

    task automatic clear_counts();
        vcnt0 = 0; ecnt0 = 0; vcnt1 = 0; ecnt1 = 0; vlat0 = -1; elat0 = -1;
    endtask

    // 10-clk serial period; data set while s_clk is low, held across the rise
    task automatic send_bits(input logic [63:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            s_dat = bits[i];
            repeat (5) @(posedge clk);
            #1 s_clk = 1'b1;
            last_rise = cyc;
            repeat (5) @(posedge clk);
            #1 s_clk = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; s_clk = 1'b0; s_dat = 1'b0; s_clr = 1'b1;
        clear_counts();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        total++; if (data0 !== 16'h0) begin bad++; $display("FAIL reset_data0 got=%h want=0000", data0); end
        total++; if (data1 !== 16'h0) begin bad++; $display("FAIL reset_data1 got=%h want=0000", data1); end
        total++; if ({valid0, err0, busy0} !== 3'b000) begin bad++; $display("FAIL reset_flags0 got=%b want=000", {valid0, err0, busy0}); end
        total++; if ({valid1, err1, busy1} !== 3'b000) begin bad++; $display("FAIL reset_flags1 got=%b want=000", {valid1, err1, busy1}); end
    endtask

    task automatic test_good_frame();
        clear_counts();
        send_bits(64'hA5C3, 16);
        total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL good_busy_mid got=%b want=1", busy0); end
        repeat (30) @(posedge clk);
        #1;
        total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL good_busy_end got=%b want=0", busy0); end
        total++; if (vcnt0 !== 1) begin bad++; $display("FAIL good_valid_cnt0 got=%0d want=1", vcnt0); end
        total++; if (ecnt0 !== 0) begin bad++; $display("FAIL good_err_cnt0 got=%0d want=0", ecnt0); end
        total++; if (data0 !== 16'hA5C3) begin bad++; $display("FAIL good_data_msb got=%h want=a5c3", data0); end
        // pin rise after posedge c: synced edge cycle c+2, valid 17 cycles after that
        total++; if (vlat0 !== 19) begin bad++; $display("FAIL good_latency got=%0d want=19", vlat0); end
        total++; if (vcnt1 !== 1) begin bad++; $display("FAIL good_valid_cnt1 got=%0d want=1", vcnt1); end
        total++; if (data1 !== 16'hC3A5) begin bad++; $display("FAIL good_data_lsb got=%h want=c3a5", data1); end
    endtask

    task automatic test_bad_length();
        clear_counts();
        send_bits(64'h5A5A, 15);
        repeat (30) @(posedge clk);
        #1;
        total++; if (ecnt0 !== 1) begin bad++; $display("FAIL short_err_cnt got=%0d want=1", ecnt0); end
        total++; if (elat0 !== 19) begin bad++; $display("FAIL short_err_latency got=%0d want=19", elat0); end
        total++; if (vcnt0 !== 0) begin bad++; $display("FAIL short_valid_cnt got=%0d want=0", vcnt0); end
        total++; if (data0 !== 16'hA5C3) begin bad++; $display("FAIL short_data_held got=%h want=a5c3", data0); end
        clear_counts();
        send_bits(64'h1FFFF, 17);
        repeat (30) @(posedge clk);
        #1;
        total++; if (ecnt0 !== 1 || ecnt1 !== 1) begin bad++; $display("FAIL long_err_cnt got=%0d/%0d want=1/1", ecnt0, ecnt1); end
        total++; if (vcnt0 !== 0 || vcnt1 !== 0) begin bad++; $display("FAIL long_valid_cnt got=%0d/%0d want=0/0", vcnt0, vcnt1); end
        total++; if (data0 !== 16'hA5C3) begin bad++; $display("FAIL long_data_held got=%h want=a5c3", data0); end
        // well past the saturation point of the bit counter
        clear_counts();
        send_bits(64'hFFFFFFFFFF, 40);
        repeat (30) @(posedge clk);
        #1;
        total++; if (ecnt0 !== 1 || vcnt0 !== 0) begin bad++; $display("FAIL sat_pulses got=err%0d/valid%0d want=err1/valid0", ecnt0, vcnt0); end
        total++; if (data1 !== 16'hC3A5) begin bad++; $display("FAIL sat_data_held got=%h want=c3a5", data1); end
    endtask

    task automatic test_clear();
        clear_counts();
        send_bits(64'hA5, 8);
        total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL clr_busy_before got=%b want=1", busy0); end
        s_clr = 1'b0;
        repeat (5) @(posedge clk);
        #1 s_clr = 1'b1;
        total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL clr_busy_after got=%b want=0", busy0); end
        repeat (30) @(posedge clk);
        #1;
        total++; if (vcnt0 + ecnt0 + vcnt1 + ecnt1 !== 0) begin bad++; $display("FAIL clr_no_pulse got=%0d want=0", vcnt0 + ecnt0 + vcnt1 + ecnt1); end
        send_bits(64'h1234, 16);
        repeat (30) @(posedge clk);
        #1;
        total++; if (vcnt0 !== 1 || ecnt0 !== 0) begin bad++; $display("FAIL clr_next_pulses got=valid%0d/err%0d want=valid1/err0", vcnt0, ecnt0); end
        total++; if (data0 !== 16'h1234) begin bad++; $display("FAIL clr_next_data_msb got=%h want=1234", data0); end
        total++; if (data1 !== 16'h2C48) begin bad++; $display("FAIL clr_next_data_lsb got=%h want=2c48", data1); end
    endtask

    task automatic test_reset_mid_frame();
        clear_counts();
        send_bits(64'h3FF, 10);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy0); end
        total++; if (data0 !== 16'h0 || data1 !== 16'h0) begin bad++; $display("FAIL rstmid_data got=%h/%h want=0000/0000", data0, data1); end
        repeat (30) @(posedge clk);
        #1;
        total++; if (vcnt0 + ecnt0 + vcnt1 + ecnt1 !== 0) begin bad++; $display("FAIL rstmid_no_pulse got=%0d want=0", vcnt0 + ecnt0 + vcnt1 + ecnt1); end
        send_bits(64'hFFFF, 16);
        repeat (30) @(posedge clk);
        #1;
        total++; if (vcnt0 !== 1 || vcnt1 !== 1) begin bad++; $display("FAIL rstmid_next_valid got=%0d/%0d want=1/1", vcnt0, vcnt1); end
        total++; if (data0 !== 16'hFFFF || data1 !== 16'hFFFF) begin bad++; $display("FAIL rstmid_next_data got=%h/%h want=ffff/ffff", data0, data1); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_length();
        test_clear();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial2parallel.md
SERIAL2PARALLEL -- requirements
Module: serial2parallel

Interface
REQ-001 The block SHALL have a parameter DATA_BITS, default 64, giving the frame width in bits.
REQ-002 The block SHALL have a parameter READ_DIRECTION, default 0; 0 means the first received bit lands in data[DATA_BITS-1] (MSB-first), 1 means it lands in data[0] (LSB-first).
REQ-003 The block SHALL have a parameter IDLE_CYCLES, default 16, giving the number of clk cycles without an s_clk rising edge that ends a frame.
REQ-004 clk  input  1  main clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 s_clk  input  1  serial clock from the transmitter; SHALL be treated as asynchronous.
REQ-007 s_dat  input  1  serial data; SHALL be valid at the s_clk rising edge.
REQ-008 s_clr  input  1  active-low shift-register clear from the transmitter.
REQ-009 data  output  DATA_BITS  last good frame, held until the next good frame.
REQ-010 valid  output  1  one-cycle pulse when data updates.
REQ-011 err  output  1  one-cycle pulse when a frame ends with a bit count other than DATA_BITS.
REQ-012 busy  output  1  high while a frame is in progress.

Function
REQ-013 s_clk, s_dat and s_clr SHALL each pass through a 2-flop synchronizer; s_dat SHALL be sampled from its synchronized copy in the same cycle the synchronized s_clk rising edge is detected.
REQ-014 The s_clk rising-edge detect SHALL be one clk cycle wide, using a third flop on synchronized s_clk.
REQ-015 FSM states SHALL be IDLE and RECV.
REQ-016 IDLE -> RECV on a detected edge; that edge's bit SHALL be shifted in and the bit count set to 1.
REQ-017 In RECV, each detected edge SHALL shift in one bit, increment the bit count, and reset the idle counter to 0.
REQ-018 In RECV, each cycle without an edge SHALL increment the idle counter.
REQ-019 When the idle counter reaches IDLE_CYCLES, the FSM SHALL return to IDLE in that same cycle.
REQ-020 On that end-of-frame cycle, if the bit count equals DATA_BITS, data SHALL load the shift register and valid SHALL be high for exactly the next cycle.
REQ-021 On that end-of-frame cycle, if the bit count is not DATA_BITS, data SHALL be unchanged and err SHALL pulse for one cycle.
REQ-022 Shift rule for READ_DIRECTION=0: sr <= {sr[DATA_BITS-2:0], bit}. Shift rule for READ_DIRECTION=1: sr <= {bit, sr[DATA_BITS-1:1]}.
REQ-023 The bit count SHALL saturate at DATA_BITS+1, so overlong frames do not wrap and still report err. Shifting SHALL continue on an overlong frame.
REQ-024 Synchronized s_clr low SHALL clear the shift register, bit count and idle counter and force IDLE, with priority over any edge in the same cycle; data SHALL be unaffected.
REQ-025 A frame interrupted by s_clr SHALL produce neither valid nor err.
REQ-026 busy SHALL equal (state == RECV).
REQ-027 The counter widths SHALL be sized from DATA_BITS+1 and IDLE_CYCLES with no overflow.
REQ-028 Latency SHALL be fixed at 3 clk cycles from the s_clk pin edge to the shift, plus IDLE_CYCLES+1 cycles from the last edge to the valid pulse.

Reset
REQ-029 On rst high, the block SHALL clear data, the shift register and all counters, and set valid=0, err=0, busy=0 and state IDLE on the next clk edge.
REQ-030 Reset mid-frame SHALL discard the partial frame with no valid or err pulse.
REQ-031 rst SHALL have priority over s_clr and edges.

Verification (DATA_BITS=16, IDLE_CYCLES=16, s_clk period 10 clk)
REQ-032 MSB-first 0xA5C3, READ_DIRECTION=0 -> exactly one valid pulse 17 cycles after the last detected edge, data=0xA5C3, err never high.
REQ-033 The same bit stream with READ_DIRECTION=1 -> data=0xC3A5 bit-reversed, i.e. data[0] equals the first bit sent.
REQ-034 15-bit frame, then a 17-bit frame -> one err pulse per frame, no valid pulse, data keeps its prior value 0xA5C3.
REQ-035 s_clr pulsed low for 5 cycles after bit 8 of a frame, then a full 16-bit frame 0x1234 -> no pulse for the first frame, valid with data=0x1234 for the second.
REQ-036 rst asserted after bit 10 -> busy=0 and data=0 the next cycle, no valid or err pulse; a following 0xFFFF frame is captured correctly.
